// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: op codes and op field width.
package reg_bank_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_NOP     = 3'd0,
    OP_LOAD    = 3'd1,
    OP_INC     = 3'd2,
    OP_DEC     = 3'd3,
    OP_LOAD_LO = 3'd4,
    OP_LOAD_HI = 3'd5
  } op_e;

endpackage

// File: rtl/reg_bank_next.sv
// Combinational next-value unit: computes the updated register value for an op,
// whether that op is a defined modifying op, and whether an INC/DEC wrapped.
module reg_bank_next
  import reg_bank_pkg::*;
#(
  parameter int NBIT = 16
) (
  input  logic [NBIT-1:0] cur,
  input  logic [NBIT-1:0] din,
  input  logic [OPW-1:0]  op,
  output logic [NBIT-1:0] nxt,
  output logic            defined,
  output logic            wrap_hit
);

  // With an 8-bit register the high lane collapses onto the low lane.
  localparam int HI_LSB = (NBIT > 8) ? 8 : 0;

  // Decode the op and form the next value; reserved codes behave as NOP.
  always_comb begin
    nxt      = cur;
    defined  = 1'b0;
    wrap_hit = 1'b0;
    case (op)
      OP_LOAD: begin
        nxt     = din;
        defined = 1'b1;
      end
      OP_INC: begin
        nxt      = cur + 1'b1;
        defined  = 1'b1;
        wrap_hit = (cur == '1);
      end
      OP_DEC: begin
        nxt      = cur - 1'b1;
        defined  = 1'b1;
        wrap_hit = (cur == '0);
      end
      OP_LOAD_LO: begin
        nxt[7:0] = din[7:0];
        defined  = 1'b1;
      end
      OP_LOAD_HI: begin
        nxt[HI_LSB +: 8] = din[7:0];
        defined          = 1'b1;
      end
      default: begin
        nxt      = cur;
        defined  = 1'b0;
        wrap_hit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// Bank of NREG registers with one write/modify port, two asynchronous read
// ports, Z/N result flags and a one-cycle INC/DEC wrap pulse.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int              NBIT      = 16,
  parameter int              NREG      = 4,
  parameter logic [NBIT-1:0] RESET_VAL = '0,
  localparam int             AW        = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [OPW-1:0]  op,
  input  logic [AW-1:0]   wsel,
  input  logic [NBIT-1:0] din,
  input  logic [AW-1:0]   raddr_a,
  output logic [NBIT-1:0] rdata_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [NBIT-1:0] rdata_b,
  output logic            flag_z,
  output logic            flag_n,
  output logic            wrap
);

  logic [NBIT-1:0] regs [NREG];

  logic            wsel_ok;
  logic [NBIT-1:0] cur;
  logic [NBIT-1:0] nxt;
  logic            defined;
  logic            wrap_hit;
  logic            fire;

  // Select the target register; an out-of-range select feeds zero and never fires.
  always_comb begin
    wsel_ok = (32'(wsel) < NREG);
    cur     = '0;
    if (wsel_ok) cur = regs[wsel];
    fire    = op_valid && wsel_ok && defined;
  end

  reg_bank_next #(
    .NBIT (NBIT)
  ) u_next (
    .cur      (cur),
    .din      (din),
    .op       (op),
    .nxt      (nxt),
    .defined  (defined),
    .wrap_hit (wrap_hit)
  );

  // Register update, flags and wrap pulse; reset overrides any pending op.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= RESET_VAL;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (fire) begin
        regs[wsel] <= nxt;
        flag_z     <= (nxt == '0);
        flag_n     <= nxt[NBIT-1];
        wrap       <= wrap_hit;
      end
    end
  end

  // Asynchronous reads of stored state; out-of-range addresses read zero.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (32'(raddr_a) < NREG) rdata_a = regs[raddr_a];
    if (32'(raddr_b) < NREG) rdata_b = regs[raddr_b];
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank: a 16x4 bank with non-zero reset
// value, an 8-bit bank for lane collapse, and a 5-entry bank for range checks.
module tb_reg_bank;
  import reg_bank_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // bank A: NBIT=16, NREG=4, RESET_VAL=0x1234
  logic        a_valid = 1'b0;
  logic [2:0]  a_op    = '0;
  logic [1:0]  a_wsel  = '0;
  logic [15:0] a_din   = '0;
  logic [1:0]  a_ra    = '0;
  logic [1:0]  a_rb    = '0;
  logic [15:0] a_rda, a_rdb;
  logic        a_z, a_n, a_wrap;

  // bank B: NBIT=8, NREG=2
  logic        b_valid = 1'b0;
  logic [2:0]  b_op    = '0;
  logic [0:0]  b_wsel  = '0;
  logic [7:0]  b_din   = '0;
  logic [0:0]  b_ra    = '0;
  logic [0:0]  b_rb    = '0;
  logic [7:0]  b_rda, b_rdb;
  logic        b_z, b_n, b_wrap;

  // bank C: NBIT=16, NREG=5
  logic        c_valid = 1'b0;
  logic [2:0]  c_op    = '0;
  logic [2:0]  c_wsel  = '0;
  logic [15:0] c_din   = '0;
  logic [2:0]  c_ra    = '0;
  logic [2:0]  c_rb    = '0;
  logic [15:0] c_rda, c_rdb;
  logic        c_z, c_n, c_wrap;

  reg_bank #(.NBIT(16), .NREG(4), .RESET_VAL(16'h1234)) u_a (
    .clk(clk), .rst(rst), .op_valid(a_valid), .op(a_op), .wsel(a_wsel),
    .din(a_din), .raddr_a(a_ra), .rdata_a(a_rda), .raddr_b(a_rb),
    .rdata_b(a_rdb), .flag_z(a_z), .flag_n(a_n), .wrap(a_wrap));

  reg_bank #(.NBIT(8), .NREG(2), .RESET_VAL(8'h00)) u_b (
    .clk(clk), .rst(rst), .op_valid(b_valid), .op(b_op), .wsel(b_wsel),
    .din(b_din), .raddr_a(b_ra), .rdata_a(b_rda), .raddr_b(b_rb),
    .rdata_b(b_rdb), .flag_z(b_z), .flag_n(b_n), .wrap(b_wrap));

  reg_bank #(.NBIT(16), .NREG(5), .RESET_VAL(16'h0000)) u_c (
    .clk(clk), .rst(rst), .op_valid(c_valid), .op(c_op), .wsel(c_wsel),
    .din(c_din), .raddr_a(c_ra), .rdata_a(c_rda), .raddr_b(c_rb),
    .rdata_b(c_rdb), .flag_z(c_z), .flag_n(c_n), .wrap(c_wrap));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // advance past the next rising edge, sampling 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_a(input logic [2:0] op, input logic [1:0] sel, input logic [15:0] d);
    a_valid = 1'b1; a_op = op; a_wsel = sel; a_din = d;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic do_b(input logic [2:0] op, input logic [0:0] sel, input logic [7:0] d);
    b_valid = 1'b1; b_op = op; b_wsel = sel; b_din = d;
    tick();
    b_valid = 1'b0;
  endtask

  task automatic do_c(input logic [2:0] op, input logic [2:0] sel, input logic [15:0] d);
    c_valid = 1'b1; c_op = op; c_wsel = sel; c_din = d;
    tick();
    c_valid = 1'b0;
  endtask

  task automatic read_a(input logic [1:0] addr, output logic [15:0] v);
    a_ra = addr;
    #1;
    v = a_rda;
  endtask

  initial begin
    logic [15:0] v;

    // 1. reset (2 cycles) then LOAD
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read_a(2'(i), v);
      check($sformatf("rst_r%0d", i), v, 16'h1234);
    end
    check("rst_z", a_z, 0);
    check("rst_n", a_n, 0);
    check("rst_wrap", a_wrap, 0);

    do_a(OP_LOAD, 2'd2, 16'h8000);
    read_a(2'd2, v);
    check("load_r2", v, 16'h8000);
    check("load_n", a_n, 1);
    check("load_z", a_z, 0);

    // 2. INC / DEC wrap
    do_a(OP_LOAD, 2'd1, 16'hFFFF);
    check("ld_ffff_wrap", a_wrap, 0);
    do_a(OP_INC, 2'd1, 16'h0000);
    read_a(2'd1, v);
    check("inc_r1", v, 16'h0000);
    check("inc_z", a_z, 1);
    check("inc_n", a_n, 0);
    check("inc_wrap", a_wrap, 1);
    tick();
    check("inc_wrap_drop", a_wrap, 0);
    check("idle_z_hold", a_z, 1);
    do_a(OP_DEC, 2'd1, 16'h0000);
    read_a(2'd1, v);
    check("dec_r1", v, 16'hFFFF);
    check("dec_wrap", a_wrap, 1);
    check("dec_n", a_n, 1);
    check("dec_z", a_z, 0);

    // 3. byte lanes
    do_a(OP_LOAD, 2'd0, 16'hABCD);
    do_a(OP_LOAD_LO, 2'd0, 16'hFF12);
    read_a(2'd0, v);
    check("load_lo", v, 16'hAB12);
    check("load_lo_n", a_n, 1);
    do_a(OP_LOAD_HI, 2'd0, 16'hFF34);
    read_a(2'd0, v);
    check("load_hi", v, 16'h3412);
    check("load_hi_n", a_n, 0);
    check("load_hi_z", a_z, 0);

    // 4. same-cycle read of the written register
    do_a(OP_LOAD, 2'd3, 16'h0010);
    a_ra = 2'd3; a_rb = 2'd2;
    a_valid = 1'b1; a_op = OP_INC; a_wsel = 2'd3; a_din = 16'h0000;
    #1;
    check("rw_old_a", a_rda, 16'h0010);
    check("rw_old_b", a_rdb, 16'h8000);
    tick();
    a_valid = 1'b0;
    check("rw_new_a", a_rda, 16'h0011);
    check("rw_new_b", a_rdb, 16'h8000);

    // 5a. rejected ops on bank A (flags z=0 n=0 before)
    a_valid = 1'b0; a_op = OP_LOAD; a_wsel = 2'd3; a_din = 16'h0000;
    tick();
    check("novalid_r3", a_rda, 16'h0011);
    check("novalid_z", a_z, 0);
    a_valid = 1'b0; a_op = OP_INC; a_wsel = 2'd1;
    tick();
    read_a(2'd1, v);
    check("novalid_inc_r1", v, 16'hFFFF);
    check("novalid_wrap", a_wrap, 0);
    do_a(3'd6, 2'd3, 16'h0000);
    read_a(2'd3, v);
    check("op6_r3", v, 16'h0011);
    check("op6_z", a_z, 0);
    do_a(3'd7, 2'd3, 16'h8000);
    read_a(2'd3, v);
    check("op7_r3", v, 16'h0011);
    check("op7_n", a_n, 0);
    check("op7_wrap", a_wrap, 0);

    // 6. reset priority over a same-cycle LOAD, with z and wrap set beforehand
    do_a(OP_INC, 2'd1, 16'h0000);
    check("pre_rst_wrap", a_wrap, 1);
    rst = 1'b1;
    do_a(OP_LOAD, 2'd0, 16'hFFFF);
    rst = 1'b0;
    read_a(2'd0, v);
    check("rstpri_r0", v, 16'h1234);
    read_a(2'd1, v);
    check("rstpri_r1", v, 16'h1234);
    check("rstpri_z", a_z, 0);
    check("rstpri_n", a_n, 0);
    check("rstpri_wrap", a_wrap, 0);

    // 3b. 8-bit bank: LOAD_HI lands in the low byte
    b_ra = 1'b0;
    do_b(OP_LOAD, 1'b0, 8'hAA);
    #1 check("b_load", b_rda, 8'hAA);
    do_b(OP_LOAD_HI, 1'b0, 8'h55);
    #1 check("b_load_hi", b_rda, 8'h55);
    check("b_load_hi_n", b_n, 0);
    do_b(OP_LOAD_LO, 1'b0, 8'h80);
    #1 check("b_load_lo", b_rda, 8'h80);
    check("b_load_lo_n", b_n, 1);
    do_b(OP_LOAD, 1'b1, 8'hFF);
    do_b(OP_INC, 1'b1, 8'h00);
    b_rb = 1'b1;
    #1 check("b_inc_r1", b_rdb, 8'h00);
    check("b_inc_wrap", b_wrap, 1);
    check("b_inc_z", b_z, 1);

    // 5b. 5-entry bank: out-of-range select and address
    do_c(OP_LOAD, 3'd4, 16'h00FF);
    do_c(OP_LOAD, 3'd5, 16'h0000);
    c_ra = 3'd4;
    #1 check("c_r4_hold", c_rda, 16'h00FF);
    check("c_wsel5_z", c_z, 0);
    check("c_wsel5_n", c_n, 0);
    do_c(OP_DEC, 3'd6, 16'h0000);
    check("c_wsel6_wrap", c_wrap, 0);
    check("c_wsel6_z", c_z, 0);
    c_ra = 3'd5; c_rb = 3'd7;
    #1 check("c_raddr5", c_rda, 16'h0000);
    check("c_raddr7", c_rdb, 16'h0000);
    c_rb = 3'd4;
    #1 check("c_r4_final", c_rdb, 16'h00FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Parametrised bank of NREG general registers, each NBIT wide, with one write/modify port and two asynchronous read ports.
- Supersedes the single strobe-written register. Adds synchronous reset, selectable operations (load, byte-lane load, increment, decrement), a wrap indicator and Z/N result flags.
- Sits in the datapath holding PC, SP, X, Y-style state for the 6502 core.

Parameters:
- NBIT, 16, register width in bits; must be a multiple of 8 and at least 8.
- NREG, 4, number of registers; at least 1.
- RESET_VAL, 0, value loaded into every register on reset (NBIT wide).
- AW, derived = max(1, $clog2(NREG)), select/address width; not user-overridable.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  qualifies op/wsel/din this cycle.
- op  in  3  operation code (see package).
- wsel  in  AW  target register index.
- din  in  NBIT  load data; LOAD_LO and LOAD_HI use din[7:0].
- raddr_a  in  AW  read select, port A.
- rdata_a  out  NBIT  contents of register raddr_a.
- raddr_b  in  AW  read select, port B.
- rdata_b  out  NBIT  contents of register raddr_b.
- flag_z  out  1  result of last executed op was zero.
- flag_n  out  1  MSB of result of last executed op.
- wrap  out  1  one-cycle pulse; last executed INC/DEC wrapped.

Behaviour:
- Reset:
  - rst=1 at a rising edge sets all registers to RESET_VAL, flag_z=0, flag_n=0, wrap=0.
  - rst has priority over any op in the same cycle.
  - Reset mid-sequence discards the pending op; nothing is partially applied.
- Execution:
  - An op executes when op_valid=1, wsel<NREG, and op is a defined non-NOP code.
  - The register update happens at that edge; single-cycle, no stall, no ready signal.
- Operations (R = regs[wsel]):
  - NOP (0): no change.
  - LOAD (1): R <= din.
  - INC (2): R <= R+1, modulo 2^NBIT.
  - DEC (3): R <= R-1, modulo 2^NBIT.
  - LOAD_LO (4): R[7:0] <= din[7:0]; other bits held.
  - LOAD_HI (5): R[15:8] <= din[7:0]; other bits held. When NBIT=8, LOAD_HI writes R[7:0].
  - 6, 7: reserved, treated as NOP.
- Flags:
  - On each executed op, flag_z <= (new R == 0) and flag_n <= new R[NBIT-1], computed on the full-width new value.
  - If no op executes, flags hold.
- Wrap:
  - wrap <= 1 for exactly one cycle after INC from all-ones or DEC from zero.
  - wrap <= 0 after every other cycle, including idle cycles.
- Reads:
  - Combinational from stored state; no write-through bypass.
  - A read of wsel during an update returns the old value; the new value is visible the cycle after the edge.
- Range checks:
  - raddr >= NREG returns 0.
  - wsel >= NREG: the op is ignored, flags hold, wrap=0.
- Concurrency: the write port and both read ports operate simultaneously and independently; both read ports may select the same register.
- op_valid=0: op, wsel and din are don't-care.

Decomposition:
- Package reg_bank_pkg holds:
  - op code localparams/typedef: OP_NOP, OP_LOAD, OP_INC, OP_DEC, OP_LOAD_LO, OP_LOAD_HI.
  - Op width constant OPW=3.
- Sub-module reg_bank_next: combinational next-value unit taking (cur, din, op) and returning (next, wrap_hit).
  - The top instantiates one reg_bank_next and muxes its result into regs[wsel].
  - Flags and wrap are computed from that next value.

Test Plan:
1. Reset and LOAD: NBIT=16, NREG=4, RESET_VAL=0x1234; assert rst 2 cycles → all reads 0x1234, flag_z=0, flag_n=0, wrap=0. Then LOAD wsel=2 din=0x8000 → rdata_a(raddr=2)=0x8000 next cycle, flag_n=1, flag_z=0.
2. INC wrap: LOAD r1=0xFFFF, then INC r1 → r1=0x0000, flag_z=1, wrap=1 for exactly one cycle, then 0. DEC r1 → 0xFFFF, wrap=1, flag_n=1.
3. Byte lanes: r0=0xABCD; LOAD_LO din=0x12 → 0xAB12; LOAD_HI din=0x34 → 0x3412. With NBIT=8, LOAD_HI din=0x55 → r=0x55.
4. Same-cycle read/write: raddr_a=3 while INC r3 from 0x0010 → rdata_a=0x0010 in the update cycle, 0x0011 the next. Port B on another register is unaffected.
5. Rejected ops: op_valid=0, reserved op 6, and wsel=5 with NREG=5 → no register, flag or wrap change. raddr=5 reads 0.
6. Reset priority: rst=1 together with LOAD r0 din=0xFFFF → r0=RESET_VAL, flags 0, wrap 0.
